modulo_counter: RTL and testbench

MODULO_COUNTER -- requirements
Module: modulo_counter

---
 rtl/modulo_counter.sv | 82 ++++++++
 tb/tb_modulo_counter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_counter.sv
`default_nettype none
// ============================================================================
// Module      : modulo_counter
// Description : Up/down counter over 0..max_val with load, wrap or saturate
//               behaviour and registered overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic [DATA_WIDTH-1:0] max_val,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  ovf,
    output logic                  unf,
    output logic                  tc
);

    localparam logic [DATA_WIDTH-1:0] c_zero = '0;
    localparam logic [DATA_WIDTH-1:0] c_one  = DATA_WIDTH'(1);
    localparam bit                    c_sat  = (SATURATE != 0);

    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] count_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  unf_q;
    logic                  unf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up) begin
                // >= also catches a count left above a freshly lowered limit
                if (count_q >= max_val) begin
                    ovf_d   = 1'b1;
                    count_d = c_sat ? max_val : c_zero;
                end else begin
                    count_d = count_q + c_one;
                end
            end else begin
                if (count_q == c_zero) begin
                    unf_d   = 1'b1;
                    count_d = c_sat ? c_zero : max_val;
                end else if (count_q > max_val) begin
                    count_d = max_val;
                end else begin
                    count_d = count_q - c_one;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= c_zero;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign tc    = up ? (count_q == max_val) : (count_q == c_zero);

endmodule
`default_nettype wire

// File: tb/tb_modulo_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulo_counter
// Description : Directed and model-based bench for three modulo_counter
//               instances (5-bit wrap, 4-bit wrap, 5-bit saturate).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [4:0] lv_a = '0, mx_a = '0, cnt_a;
    logic [3:0] lv_b = '0, mx_b = '0, cnt_b;
    logic [4:0] lv_c = '0, mx_c = '0, cnt_c;
    logic       ovf_a, unf_a, tc_a;
    logic       ovf_b, unf_b, tc_b;
    logic       ovf_c, unf_c, tc_c;

    int total = 0;
    int bad   = 0;

    modulo_counter #(.DATA_WIDTH(5), .SATURATE(0)) u_a (
        .clk(clk), .reset(rst_n), .en(en), .up(up), .load(load),
        .load_val(lv_a), .max_val(mx_a), .count(cnt_a), .ovf(ovf_a), .unf(unf_a), .tc(tc_a));
    modulo_counter #(.DATA_WIDTH(4), .SATURATE(0)) u_b (
        .clk(clk), .reset(rst_n), .en(en), .up(up), .load(load),
        .load_val(lv_b), .max_val(mx_b), .count(cnt_b), .ovf(ovf_b), .unf(unf_b), .tc(tc_b));
    modulo_counter #(.DATA_WIDTH(5), .SATURATE(1)) u_c (
        .clk(clk), .reset(rst_n), .en(en), .up(up), .load(load),
        .load_val(lv_c), .max_val(mx_c), .count(cnt_c), .ovf(ovf_c), .unf(unf_c), .tc(tc_c));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    function automatic void ref_step(input int cnt, input bit e, input bit u, input bit l,
                                     input int lv, input int mx, input bit sat,
                                     output int nc, output bit o, output bit un);
        nc = cnt; o = 1'b0; un = 1'b0;
        if (l) nc = (lv > mx) ? mx : lv;
        else if (e) begin
            if (u) begin
                if (cnt >= mx) begin o = 1'b1; nc = sat ? mx : 0; end
                else nc = cnt + 1;
            end else begin
                if (cnt == 0) begin un = 1'b1; nc = sat ? 0 : mx; end
                else if (cnt > mx) nc = mx;
                else nc = cnt - 1;
            end
        end
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cnt_a, ovf_a, unf_a, cnt_b, ovf_b, unf_b, cnt_c, ovf_c, unf_c} !== '0) begin
            bad++;
            $display("FAIL reset_async: a=%0d/%b/%b b=%0d/%b/%b c=%0d/%b/%b want all 0",
                     cnt_a, ovf_a, unf_a, cnt_b, ovf_b, unf_b, cnt_c, ovf_c, unf_c);
        end
        load = 1'b1; lv_a = 5'd7; mx_a = 5'd20; en = 1'b1; up = 1'b1;
        tick(); tick();
        total++;
        if ({cnt_a, ovf_a, unf_a} !== {5'd0, 2'b00}) begin
            bad++;
            $display("FAIL reset_holds: got cnt=%0d ovf=%b unf=%b want 0/0/0", cnt_a, ovf_a, unf_a);
        end
        load = 1'b0; en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        int ea, eb;
        do_reset();
        mx_a = 5'd31; mx_b = 4'd15; up = 1'b1; en = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            ea = e % 32;
            eb = e % 16;
            total++;
            if ({cnt_a, ovf_a, unf_a, tc_a} !== {5'(ea), (e == 32), 1'b0, (ea == 31)}) begin
                bad++;
                $display("FAIL wrap_up_a edge %0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b tc=%b",
                         e, cnt_a, ovf_a, unf_a, tc_a, ea, (e == 32), (ea == 31));
            end
            total++;
            if ({cnt_b, ovf_b, unf_b} !== {4'(eb), (eb == 0), 1'b0}) begin
                bad++;
                $display("FAIL wrap_up_b edge %0d: got cnt=%0d ovf=%b unf=%b want cnt=%0d ovf=%b",
                         e, cnt_b, ovf_b, unf_b, eb, (eb == 0));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        do_reset();
        en = 1'b0; up = 1'b0; mx_a = 5'd9; mx_b = 4'd9;
        #1;
        total++;
        if (tc_a !== 1'b1) begin
            bad++;
            $display("FAIL down_tc_at_zero: got tc=%b want 1", tc_a);
        end
        en = 1'b1;
        tick();
        total++;
        if ({cnt_a, ovf_a, unf_a, tc_a, cnt_b, unf_b} !== {5'd9, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1}) begin
            bad++;
            $display("FAIL down_edge1: got a=%0d/%b/%b tc=%b b=%0d/%b want a=9 ovf=0 unf=1 tc=0 b=9 unf=1",
                     cnt_a, ovf_a, unf_a, tc_a, cnt_b, unf_b);
        end
        for (int e = 2; e <= 10; e++) begin
            tick();
            total++;
            if ({cnt_a, unf_a, tc_a} !== {5'(10 - e), 1'b0, (e == 10)}) begin
                bad++;
                $display("FAIL down_edge%0d: got cnt=%0d unf=%b tc=%b want cnt=%0d unf=0 tc=%b",
                         e, cnt_a, unf_a, tc_a, 10 - e, (e == 10));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        int ec;
        do_reset();
        mx_c = 5'd6; up = 1'b1; en = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            ec = (e < 6) ? e : 6;
            total++;
            if ({cnt_c, ovf_c, unf_c, tc_c} !== {5'(ec), (e >= 7), 1'b0, (ec == 6)}) begin
                bad++;
                $display("FAIL sat_up edge %0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d ovf=%b",
                         e, cnt_c, ovf_c, unf_c, tc_c, ec, (e >= 7));
            end
        end
        up = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            ec = (e <= 6) ? 6 - e : 0;
            total++;
            if ({cnt_c, ovf_c, unf_c, tc_c} !== {5'(ec), 1'b0, (e >= 7), (ec == 0)}) begin
                bad++;
                $display("FAIL sat_down edge %0d: got cnt=%0d ovf=%b unf=%b tc=%b want cnt=%0d unf=%b",
                         e, cnt_c, ovf_c, unf_c, tc_c, ec, (e >= 7));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clamp();
        en = 1'b1; up = 1'b1; load = 1'b1;
        lv_a = 5'd20; mx_a = 5'd12; lv_b = 4'd14; mx_b = 4'd12;
        tick();
        load = 1'b0;
        total++;
        if ({cnt_a, ovf_a, unf_a, tc_a, cnt_b, ovf_b} !== {5'd12, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0}) begin
            bad++;
            $display("FAIL load_clamp: got a=%0d/%b/%b tc=%b b=%0d/%b want a=12 ovf=0 unf=0 tc=1 b=12 ovf=0",
                     cnt_a, ovf_a, unf_a, tc_a, cnt_b, ovf_b);
        end
        mx_a = 5'd4; mx_b = 4'd4; up = 1'b0;
        tick();
        total++;
        if ({cnt_a, ovf_a, unf_a, cnt_b, unf_b} !== {5'd4, 1'b0, 1'b0, 4'd4, 1'b0}) begin
            bad++;
            $display("FAIL lowered_max: got a=%0d/%b/%b b=%0d/%b want a=4 b=4 no pulses",
                     cnt_a, ovf_a, unf_a, cnt_b, unf_b);
        end
        load = 1'b1; lv_a = 5'd3;
        tick();
        load = 1'b0; en = 1'b0;
        total++;
        if (cnt_a !== 5'd3) begin
            bad++;
            $display("FAIL load_in_range: got cnt=%0d want 3", cnt_a);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mx_a = 5'd31; lv_a = 5'd17; load = 1'b1;
        tick();
        load = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({cnt_a, ovf_a, unf_a} !== {5'd0, 2'b00}) begin
            bad++;
            $display("FAIL midcount_reset: got cnt=%0d ovf=%b unf=%b want 0/0/0", cnt_a, ovf_a, unf_a);
        end
        rst_n = 1'b1; en = 1'b1; up = 1'b1;
        tick();
        total++;
        if ({cnt_a, ovf_a} !== {5'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_release: got cnt=%0d ovf=%b want cnt=1 ovf=0", cnt_a, ovf_a);
        end
        mx_a = 5'd1;
        tick();
        total++;
        if ({cnt_a, ovf_a} !== {5'd0, 1'b1}) begin
            bad++;
            $display("FAIL pulse_setup: got cnt=%0d ovf=%b want cnt=0 ovf=1", cnt_a, ovf_a);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cnt_a, ovf_a, unf_a} !== {5'd0, 2'b00}) begin
            bad++;
            $display("FAIL midpulse_reset: got cnt=%0d ovf=%b unf=%b want 0/0/0", cnt_a, ovf_a, unf_a);
        end
        rst_n = 1'b1; en = 1'b0;
    endtask

    task automatic test_zero_max();
        do_reset();
        mx_a = 5'd0; mx_b = 4'd0; en = 1'b1;
        for (int e = 0; e < 6; e++) begin
            up = (e < 3);
            tick();
            total++;
            if ({cnt_a, ovf_a, unf_a, tc_a, cnt_b, ovf_b, unf_b} !==
                {5'd0, (e < 3), (e >= 3), 1'b1, 4'd0, (e < 3), (e >= 3)}) begin
                bad++;
                $display("FAIL zero_max step %0d: got a=%0d/%b/%b tc=%b b=%0d/%b/%b want ovf=%b unf=%b",
                         e, cnt_a, ovf_a, unf_a, tc_a, cnt_b, ovf_b, unf_b, (e < 3), (e >= 3));
            end
        end
        en = 1'b0;
        tick();
        total++;
        if ({ovf_a, unf_a, ovf_b, unf_b} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_no_pulse: got a=%b/%b b=%b/%b want all 0", ovf_a, unf_a, ovf_b, unf_b);
        end
    endtask

    task automatic test_edge_sampling();
        do_reset();
        mx_a = 5'd31; en = 1'b0; up = 1'b0;
        #1;
        total++;
        if (tc_a !== 1'b1) begin
            bad++;
            $display("FAIL tc_follows_up0: got %b want 1", tc_a);
        end
        up = 1'b1;
        #1;
        total++;
        if (tc_a !== 1'b0) begin
            bad++;
            $display("FAIL tc_follows_up1: got %b want 0", tc_a);
        end
        tick();
        en = 1'b1;
        #2 en = 1'b0;
        tick();
        total++;
        if ({cnt_a, ovf_a} !== {5'd0, 1'b0}) begin
            bad++;
            $display("FAIL glitch_en_ignored: got cnt=%0d ovf=%b want 0/0", cnt_a, ovf_a);
        end
    endtask

    task automatic test_model();
        int ma, mb, mc, na, nb, nc;
        bit oa, ua, ob, ub, oc, uc;
        do_reset();
        ma = 0; mb = 0; mc = 0;
        mx_a = 5'd20; mx_b = 4'd15; mx_c = 5'd31;
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = ($urandom_range(0, 2) != 0);
            load = ($urandom_range(0, 15) == 0);
            lv_a = 5'($urandom_range(0, 31));
            lv_b = 4'($urandom_range(0, 15));
            lv_c = 5'($urandom_range(0, 31));
            if (i % 25 == 0) begin
                mx_a = (i % 100 == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                mx_b = (i % 75 == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                mx_c = 5'($urandom_range(0, 31));
            end
            ref_step(ma, en, up, load, int'(lv_a), int'(mx_a), 1'b0, na, oa, ua);
            ref_step(mb, en, up, load, int'(lv_b), int'(mx_b), 1'b0, nb, ob, ub);
            ref_step(mc, en, up, load, int'(lv_c), int'(mx_c), 1'b1, nc, oc, uc);
            tick();
            ma = na; mb = nb; mc = nc;
            total++;
            if ({cnt_a, ovf_a, unf_a, tc_a} !== {5'(ma), oa, ua,
                 (up ? (ma == int'(mx_a)) : (ma == 0))}) begin
                bad++;
                $display("FAIL model_a cyc %0d: got %0d/%b/%b tc=%b want %0d/%b/%b", i,
                         cnt_a, ovf_a, unf_a, tc_a, ma, oa, ua);
            end
            total++;
            if ({cnt_b, ovf_b, unf_b, tc_b} !== {4'(mb), ob, ub,
                 (up ? (mb == int'(mx_b)) : (mb == 0))}) begin
                bad++;
                $display("FAIL model_b cyc %0d: got %0d/%b/%b tc=%b want %0d/%b/%b", i,
                         cnt_b, ovf_b, unf_b, tc_b, mb, ob, ub);
            end
            total++;
            if ({cnt_c, ovf_c, unf_c, (ovf_c & unf_c) | (ovf_a & unf_a)} !== {5'(mc), oc, uc, 1'b0}) begin
                bad++;
                $display("FAIL model_c cyc %0d: got %0d/%b/%b want %0d/%b/%b", i,
                         cnt_c, ovf_c, unf_c, mc, oc, uc);
            end
        end
        en = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_clamp();
        test_async_reset();
        test_zero_max();
        test_edge_sampling();
        test_model();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
